// File: rtl/write_back_pkg.sv
// Shared constants and types for the write-back stage: hazard conditions,
// MIPS opcode/funct codes, load kinds, forwarding classes and the pipeline register layout.
package write_back_pkg;

  localparam logic [1:0]  COND_FLOW  = 2'b00;
  localparam logic [1:0]  COND_STALL = 2'b01;
  localparam logic [1:0]  COND_ZERO  = 2'b10;
  localparam logic [31:0] IR_NON     = 32'h0000_0000;

  localparam logic [5:0] OP_SPECIAL = 6'h00, OP_J    = 6'h02, OP_JAL  = 6'h03;
  localparam logic [5:0] OP_ADDI    = 6'h08, OP_ADDIU = 6'h09, OP_SLTI = 6'h0A, OP_SLTIU = 6'h0B;
  localparam logic [5:0] OP_ANDI    = 6'h0C, OP_ORI  = 6'h0D, OP_XORI = 6'h0E, OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_COP0    = 6'h10;
  localparam logic [5:0] OP_LB      = 6'h20, OP_LH   = 6'h21, OP_LW   = 6'h23;
  localparam logic [5:0] OP_LBU     = 6'h24, OP_LHU  = 6'h25;

  localparam logic [5:0] FN_SLL  = 6'h00, FN_SRL  = 6'h02, FN_SRA  = 6'h03;
  localparam logic [5:0] FN_SLLV = 6'h04, FN_SRLV = 6'h06, FN_SRAV = 6'h07;
  localparam logic [5:0] FN_JALR = 6'h09;
  localparam logic [5:0] FN_MFHI = 6'h10, FN_MTHI = 6'h11, FN_MFLO = 6'h12, FN_MTLO = 6'h13;
  localparam logic [5:0] FN_MULT = 6'h18, FN_MULTU = 6'h19, FN_DIV = 6'h1A, FN_DIVU = 6'h1B;
  localparam logic [5:0] FN_ADD  = 6'h20, FN_ADDU = 6'h21, FN_SUB  = 6'h22, FN_SUBU = 6'h23;
  localparam logic [5:0] FN_AND  = 6'h24, FN_OR   = 6'h25, FN_XOR  = 6'h26, FN_NOR  = 6'h27;
  localparam logic [5:0] FN_SLT  = 6'h2A, FN_SLTU = 6'h2B;

  localparam logic [4:0] RS_MFC0 = 5'h00, RS_MTC0 = 5'h04;

  localparam logic [1:0] FWD_GPR = 2'b00, FWD_HI = 2'b01, FWD_LO = 2'b10, FWD_CP0 = 2'b11;

  typedef enum logic [2:0] {LD_W, LD_B, LD_BU, LD_H, LD_HU} load_e;

  typedef struct packed {
    logic [31:0] ir;
    logic [31:0] res;
    logic [31:0] res2;
    logic [31:0] rdata;
    logic [1:0]  alo;
  } wb_reg_t;

  localparam wb_reg_t WB_REG_NON = '{IR_NON, 32'h0, 32'h0, 32'h0, 2'b00};

  function automatic logic [6:0] fwd_tag(input logic [1:0] cls, input logic [4:0] idx);
    return {cls, idx};
  endfunction

endpackage

// File: rtl/write_back_if.sv
// MEM-to-WB inputs and the register-file / HI-LO / CP0 write port driven by write-back.
interface write_back_if;
  logic [1:0]  cond;
  logic [31:0] mem_IR;
  logic [31:0] mem_result;
  logic [31:0] mem_result2;
  logic [31:0] mem_rdata;
  logic [1:0]  mem_addr_lo;

  logic [31:0] wb_IR;
  logic [4:0]  regfile_Rdc;
  logic [31:0] regfile_Rd;
  logic [31:0] Rd_out_for_LO;
  logic        regfile_wena;
  logic        hi_w;
  logic        lo_w;
  logic        cp0_wena;
  logic [6:0]  fwd_waddr;
  logic [31:0] fwd_wdata;

  modport master (
    output cond, mem_IR, mem_result, mem_result2, mem_rdata, mem_addr_lo,
    input  wb_IR, regfile_Rdc, regfile_Rd, Rd_out_for_LO, regfile_wena,
           hi_w, lo_w, cp0_wena, fwd_waddr, fwd_wdata
  );

  modport slave (
    input  cond, mem_IR, mem_result, mem_result2, mem_rdata, mem_addr_lo,
    output wb_IR, regfile_Rdc, regfile_Rd, Rd_out_for_LO, regfile_wena,
           hi_w, lo_w, cp0_wena, fwd_waddr, fwd_wdata
  );
endinterface

// File: rtl/write_back_load_align.sv
// Little-endian load extraction: picks the byte/halfword at the load offset and extends it.
module write_back_load_align
  import write_back_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  offset,
  input  load_e       ld_type,
  output logic [31:0] word
);

  logic [7:0]  byte_v;
  logic [15:0] half_v;

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    byte_v = rdata[7:0];
    case (offset)
      2'd1:    byte_v = rdata[15:8];
      2'd2:    byte_v = rdata[23:16];
      2'd3:    byte_v = rdata[31:24];
      default: byte_v = rdata[7:0];
    endcase
    half_v = offset[1] ? rdata[31:16] : rdata[15:0];

    word = rdata;
    case (ld_type)
      LD_B:    word = {{24{byte_v[7]}}, byte_v};
      LD_BU:   word = {24'h0, byte_v};
      LD_H:    word = {{16{half_v[15]}}, half_v};
      LD_HU:   word = {16'h0, half_v};
      default: word = rdata;
    endcase
  end

endmodule

// File: rtl/write_back.sv
// Write-back stage: latches MEM results, decodes register-file/HI/LO/CP0 writes and forwarding tag.
// Optional WB_TRACE_EN adds retire_cnt and commit_valid.
module write_back
  import write_back_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  write_back_if.slave bus
`ifdef WB_TRACE_EN
  ,
  output logic [31:0] retire_cnt,
  output logic        commit_valid
`endif
);

  wb_reg_t r;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r <= WB_REG_NON;
    end else begin
      case (bus.cond)
        COND_FLOW:  r <= '{bus.mem_IR, bus.mem_result, bus.mem_result2, bus.mem_rdata, bus.mem_addr_lo};
        COND_ZERO:  r <= WB_REG_NON;
        default:    r <= r;
      endcase
    end
  end

  logic [5:0] op, fn;
  logic [4:0] rs, rt, rd, dest;
  logic       gpr_w, hi_wr, lo_wr, cp0_wr, is_load;
  load_e      ld_type;

  assign op = r.ir[31:26];
  assign rs = r.ir[25:21];
  assign rt = r.ir[20:16];
  assign rd = r.ir[15:11];
  assign fn = r.ir[5:0];

  always_comb begin
    gpr_w   = 1'b0;
    hi_wr   = 1'b0;
    lo_wr   = 1'b0;
    cp0_wr  = 1'b0;
    is_load = 1'b0;
    ld_type = LD_W;
    dest    = 5'd0;
    case (op)
      OP_SPECIAL: begin
        case (fn)
          FN_SLL, FN_SRL, FN_SRA, FN_SLLV, FN_SRLV, FN_SRAV,
          FN_ADD, FN_ADDU, FN_SUB, FN_SUBU, FN_AND, FN_OR, FN_XOR, FN_NOR,
          FN_SLT, FN_SLTU, FN_JALR, FN_MFHI, FN_MFLO: begin
            gpr_w = 1'b1;
            dest  = rd;
          end
          FN_MTHI: hi_wr = 1'b1;
          FN_MTLO: lo_wr = 1'b1;
          FN_MULT, FN_MULTU, FN_DIV, FN_DIVU: begin
            hi_wr = 1'b1;
            lo_wr = 1'b1;
          end
          default: ;
        endcase
      end
      OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU, OP_ANDI, OP_ORI, OP_XORI, OP_LUI: begin
        gpr_w = 1'b1;
        dest  = rt;
      end
      OP_LB, OP_LBU, OP_LH, OP_LHU, OP_LW: begin
        gpr_w   = 1'b1;
        is_load = 1'b1;
        dest    = rt;
        case (op)
          OP_LB:   ld_type = LD_B;
          OP_LBU:  ld_type = LD_BU;
          OP_LH:   ld_type = LD_H;
          OP_LHU:  ld_type = LD_HU;
          default: ld_type = LD_W;
        endcase
      end
      OP_JAL: begin
        gpr_w = 1'b1;
        dest  = 5'd31;
      end
      OP_COP0: begin
        if (rs == RS_MFC0) begin
          gpr_w = 1'b1;
          dest  = rt;
        end else if (rs == RS_MTC0) begin
          cp0_wr = 1'b1;
          dest   = rd;
        end
      end
      default: ;
    endcase
  end

  logic [31:0] ld_word, wr_data;
  logic        gpr_en;

  write_back_load_align u_load_align (
    .rdata   (r.rdata),
    .offset  (r.alo),
    .ld_type (ld_type),
    .word    (ld_word)
  );

  // A write to $0 is dropped here, which also makes the all-zero bubble commit nothing.
  assign gpr_en  = gpr_w && (dest != 5'd0);
  assign wr_data = is_load ? ld_word : r.res;

  assign bus.wb_IR         = r.ir;
  assign bus.regfile_Rdc   = dest;
  assign bus.regfile_Rd    = wr_data;
  assign bus.regfile_wena  = gpr_en;
  assign bus.hi_w          = hi_wr;
  assign bus.lo_w          = lo_wr;
  assign bus.cp0_wena      = cp0_wr;
  assign bus.Rd_out_for_LO = (hi_wr && lo_wr) ? r.res2 : 32'h0;

  // Mult/div reports only HI; the LO half reaches forwarding through Rd_out_for_LO.
  always_comb begin
    bus.fwd_waddr = 7'h0;
    bus.fwd_wdata = 32'h0;
    if (gpr_en) begin
      bus.fwd_waddr = fwd_tag(FWD_GPR, dest);
      bus.fwd_wdata = wr_data;
    end else if (cp0_wr) begin
      bus.fwd_waddr = fwd_tag(FWD_CP0, dest);
      bus.fwd_wdata = r.res;
    end else if (hi_wr) begin
      bus.fwd_waddr = fwd_tag(FWD_HI, 5'd0);
      bus.fwd_wdata = r.res;
    end else if (lo_wr) begin
      bus.fwd_waddr = fwd_tag(FWD_LO, 5'd0);
      bus.fwd_wdata = r.res;
    end
  end

`ifdef WB_TRACE_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      retire_cnt <= 32'h0;
    end else if (bus.cond == COND_FLOW && bus.mem_IR != IR_NON && retire_cnt != 32'hFFFF_FFFF) begin
      retire_cnt <= retire_cnt + 32'd1;
    end
  end

  assign commit_valid = (r.ir != IR_NON);
`endif

endmodule

// File: tb/tb_write_back.sv
// Scoreboard bench for write_back: each driven cycle queues its expected port state,
// a monitor compares after the following rising edge.
module tb_write_back;
  import write_back_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  write_back_if bus();

`ifdef WB_TRACE_EN
  logic [31:0] retire_cnt;
  logic        commit_valid;
  write_back dut (.clk(clk), .rst(rst), .bus(bus), .retire_cnt(retire_cnt), .commit_valid(commit_valid));
`else
  write_back dut (.clk(clk), .rst(rst), .bus(bus));
`endif

  typedef struct {
    string       name;
    logic [31:0] ir;
    logic [4:0]  rdc;
    logic [31:0] rd;
    logic [31:0] lo;
    logic        wena;
    logic        hi;
    logic        low;
    logic        cp0;
    logic [6:0]  fa;
    logic [31:0] fd;
  } exp_t;

  exp_t q[$];
  int   n_vec  = 0;
  int   n_fail = 0;

  function automatic exp_t mk(input logic [31:0] ir, input logic [4:0] rdc, input logic [31:0] rd,
                              input logic [31:0] lo, input logic wena, input logic hi, input logic low,
                              input logic cp0, input logic [6:0] fa, input logic [31:0] fd);
    exp_t e;
    e.name = "";
    e.ir = ir; e.rdc = rdc; e.rd = rd; e.lo = lo; e.wena = wena;
    e.hi = hi; e.low = low; e.cp0 = cp0; e.fa = fa; e.fd = fd;
    return e;
  endfunction

  task automatic apply(input string nm, input logic r, input logic [1:0] c,
                       input logic [31:0] ir, input logic [31:0] res, input logic [31:0] res2,
                       input logic [31:0] rdata, input logic [1:0] alo, input exp_t e);
    @(negedge clk);
    rst             = r;
    bus.cond        = c;
    bus.mem_IR      = ir;
    bus.mem_result  = res;
    bus.mem_result2 = res2;
    bus.mem_rdata   = rdata;
    bus.mem_addr_lo = alo;
    e.name = nm;
    q.push_back(e);
  endtask

  task automatic check(input exp_t e);
    n_vec++;
    if (bus.wb_IR !== e.ir || bus.regfile_Rdc !== e.rdc || bus.regfile_Rd !== e.rd ||
        bus.Rd_out_for_LO !== e.lo || bus.regfile_wena !== e.wena || bus.hi_w !== e.hi ||
        bus.lo_w !== e.low || bus.cp0_wena !== e.cp0 || bus.fwd_waddr !== e.fa || bus.fwd_wdata !== e.fd) begin
      n_fail++;
      $display("FAIL %s: got ir=%h rdc=%0d rd=%h lo=%h wena=%b hi=%b lo_w=%b cp0=%b fa=%h fd=%h ; want ir=%h rdc=%0d rd=%h lo=%h wena=%b hi=%b lo_w=%b cp0=%b fa=%h fd=%h",
               e.name, bus.wb_IR, bus.regfile_Rdc, bus.regfile_Rd, bus.Rd_out_for_LO, bus.regfile_wena,
               bus.hi_w, bus.lo_w, bus.cp0_wena, bus.fwd_waddr, bus.fwd_wdata,
               e.ir, e.rdc, e.rd, e.lo, e.wena, e.hi, e.low, e.cp0, e.fa, e.fd);
    end
  endtask

  // Monitor: the register updates on the rising edge; outputs are sampled 2 ns later.
  initial begin
    forever begin
      @(posedge clk);
      #2;
      if (q.size() > 0) check(q.pop_front());
    end
  end

  localparam logic [31:0] ADDU  = 32'h0022_1821;  // addu $3,$1,$2
  localparam logic [31:0] LB    = 32'h8004_0000;  // lb   $4,0($0)
  localparam logic [31:0] LBU   = 32'h9004_0000;
  localparam logic [31:0] LH    = 32'h8404_0000;
  localparam logic [31:0] LHU   = 32'h9404_0000;
  localparam logic [31:0] LW    = 32'h8C04_0000;
  localparam logic [31:0] MULT  = 32'h0022_0018;  // mult $1,$2
  localparam logic [31:0] MTHI  = 32'h00E0_0011;  // mthi $7
  localparam logic [31:0] MTLO  = 32'h00E0_0013;  // mtlo $7
  localparam logic [31:0] JAL   = 32'h0C00_0100;
  localparam logic [31:0] SW    = 32'hAC04_0000;
  localparam logic [31:0] ADDI0 = 32'h2400_0007;  // addiu $0,$0,7
  localparam logic [31:0] MTC0  = 32'h4085_7000;  // mtc0 $5,$14
  localparam logic [31:0] MFC0  = 32'h4008_6000;  // mfc0 $8,$12
  localparam logic [31:0] RDATA = 32'h1234_80FF;

  exp_t zero_e, mtc0_e;

  initial begin
    bus.cond = COND_FLOW; bus.mem_IR = 32'h0; bus.mem_result = 32'h0;
    bus.mem_result2 = 32'h0; bus.mem_rdata = 32'h0; bus.mem_addr_lo = 2'd0;
    zero_e = mk(32'h0, 5'd0, 32'h0, 32'h0, 0, 0, 0, 0, 7'h00, 32'h0);
    q.push_back(zero_e);
    q[0].name = "reset_init";

    apply("addu",     0, COND_FLOW, ADDU, 32'h5, 32'h0, 32'h0, 2'd0,
          mk(ADDU, 5'd3, 32'h5, 32'h0, 1, 0, 0, 0, 7'h03, 32'h5));
    // Little-endian: offset 2 is bits [23:16] = 8'h34, offset 1 is bits [15:8] = 8'h80.
    apply("lb_off2",  0, COND_FLOW, LB,  32'h0, 32'h0, RDATA, 2'd2,
          mk(LB,  5'd4, 32'h0000_0034, 32'h0, 1, 0, 0, 0, 7'h04, 32'h0000_0034));
    apply("lb_off1",  0, COND_FLOW, LB,  32'h0, 32'h0, RDATA, 2'd1,
          mk(LB,  5'd4, 32'hFFFF_FF80, 32'h0, 1, 0, 0, 0, 7'h04, 32'hFFFF_FF80));
    apply("lbu_off1", 0, COND_FLOW, LBU, 32'h0, 32'h0, RDATA, 2'd1,
          mk(LBU, 5'd4, 32'h0000_0080, 32'h0, 1, 0, 0, 0, 7'h04, 32'h0000_0080));
    apply("lbu_off2", 0, COND_FLOW, LBU, 32'h0, 32'h0, RDATA, 2'd2,
          mk(LBU, 5'd4, 32'h0000_0034, 32'h0, 1, 0, 0, 0, 7'h04, 32'h0000_0034));
    apply("lh_off3",  0, COND_FLOW, LH,  32'h0, 32'h0, RDATA, 2'd3,
          mk(LH,  5'd4, 32'h0000_1234, 32'h0, 1, 0, 0, 0, 7'h04, 32'h0000_1234));
    apply("lhu_off0", 0, COND_FLOW, LHU, 32'h0, 32'h0, RDATA, 2'd0,
          mk(LHU, 5'd4, 32'h0000_80FF, 32'h0, 1, 0, 0, 0, 7'h04, 32'h0000_80FF));
    apply("lh_off1",  0, COND_FLOW, LH,  32'h0, 32'h0, RDATA, 2'd1,
          mk(LH,  5'd4, 32'hFFFF_80FF, 32'h0, 1, 0, 0, 0, 7'h04, 32'hFFFF_80FF));
    apply("lw",       0, COND_FLOW, LW,  32'h0, 32'h0, RDATA, 2'd0,
          mk(LW,  5'd4, RDATA, 32'h0, 1, 0, 0, 0, 7'h04, RDATA));
    apply("mult",     0, COND_FLOW, MULT, 32'hAAAA_0001, 32'h5555_0002, 32'h0, 2'd0,
          mk(MULT, 5'd0, 32'hAAAA_0001, 32'h5555_0002, 0, 1, 1, 0, 7'h20, 32'hAAAA_0001));
    apply("mthi",     0, COND_FLOW, MTHI, 32'hDEAD_BEEF, 32'h1111_1111, 32'h0, 2'd0,
          mk(MTHI, 5'd0, 32'hDEAD_BEEF, 32'h0, 0, 1, 0, 0, 7'h20, 32'hDEAD_BEEF));
    apply("mtlo",     0, COND_FLOW, MTLO, 32'hCAFE_F00D, 32'h2222_2222, 32'h0, 2'd0,
          mk(MTLO, 5'd0, 32'hCAFE_F00D, 32'h0, 0, 0, 1, 0, 7'h40, 32'hCAFE_F00D));
    apply("jal",      0, COND_FLOW, JAL, 32'h0040_0008, 32'h0, 32'h0, 2'd0,
          mk(JAL, 5'd31, 32'h0040_0008, 32'h0, 1, 0, 0, 0, 7'h1F, 32'h0040_0008));
    apply("sw",       0, COND_FLOW, SW, 32'h0000_0010, 32'h0, 32'h99, 2'd0,
          mk(SW, 5'd0, 32'h0000_0010, 32'h0, 0, 0, 0, 0, 7'h00, 32'h0));
    apply("addiu_r0", 0, COND_FLOW, ADDI0, 32'h7, 32'h0, 32'h0, 2'd0,
          mk(ADDI0, 5'd0, 32'h7, 32'h0, 0, 0, 0, 0, 7'h00, 32'h0));
    apply("cond_zero", 0, COND_ZERO, ADDU, 32'h5, 32'h0, 32'h0, 2'd0, zero_e);

    mtc0_e = mk(MTC0, 5'd14, 32'h0040_0010, 32'h0, 0, 0, 0, 1, 7'h6E, 32'h0040_0010);
    apply("mtc0",     0, COND_FLOW,  MTC0, 32'h0040_0010, 32'h0, 32'h0, 2'd0, mtc0_e);
    apply("stall1",   0, COND_STALL, ADDU, 32'h5, 32'h0, 32'h0, 2'd0, mtc0_e);
    apply("stall2",   0, COND_STALL, MULT, 32'h1, 32'h2, 32'h3, 2'd3, mtc0_e);
    apply("cond_11",  0, 2'b11,      JAL,  32'h8, 32'h0, 32'h0, 2'd1, mtc0_e);

    apply("mfc0",     0, COND_FLOW, MFC0, 32'h0000_1234, 32'h0, 32'h0, 2'd0,
          mk(MFC0, 5'd8, 32'h0000_1234, 32'h0, 1, 0, 0, 0, 7'h08, 32'h0000_1234));
    apply("addu2",    0, COND_FLOW, ADDU, 32'h9, 32'h0, 32'h0, 2'd0,
          mk(ADDU, 5'd3, 32'h9, 32'h0, 1, 0, 0, 0, 7'h03, 32'h9));
    apply("reset_mid", 1, COND_FLOW, ADDU, 32'h77, 32'h0, 32'h0, 2'd0, zero_e);
    apply("post_rst", 0, COND_STALL, ADDU, 32'h77, 32'h0, 32'h0, 2'd0, zero_e);

    for (int i = 0; i < 10 && q.size() > 0; i++) begin
      @(posedge clk);
      #3;
    end
    if (q.size() != 0) begin
      n_vec++;
      n_fail++;
      $display("FAIL drain: %0d expectations left, want 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
